// File: rtl/slow_mem_pkg.sv
// Shared types and constants for the slow line-memory responder.
// SLOW_MEM_RANDLAT_EN (see slow_mem_responder) consumes the LFSR constants.
package slow_mem_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/slow_mem_lfsr.sv
// 8-bit Fibonacci LFSR that advances only when step_i is high.
module slow_mem_lfsr
  import slow_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = step_i ? {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
  assign lfsr_o = lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/slow_mem_responder.sv
// Line-memory responder answering cache line reads/writes after a fixed latency.
// Define SLOW_MEM_RANDLAT_EN to add 0..3 pseudo-random extra cycles per request.
module slow_mem_responder
  import slow_mem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 8,
  parameter int LINE_W     = slow_mem_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready
);

  // Request sampled in IDLE plus one BUSY cycle per count down to zero gives LATENCY.
  localparam logic [8:0] CNT_LOAD = 9'(LATENCY - 2);

  logic [LINE_W-1:0]     mem_q [2**DEPTH_LOG2];
  state_t                state_q;
  logic [8:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [LINE_W-1:0]     wdata_q;
  logic                  wr_q;
  logic [LINE_W-1:0]     rdata_q;
  logic                  ready_q;

  logic                  req;
  logic                  accept;
  logic                  access;
  logic [8:0]            cnt_load;
  logic                  unused_addr;

  assign req         = mem_read | mem_write;
  assign accept      = (state_q == IDLE) && req;
  assign access      = (state_q == BUSY) && (cnt_q == 9'd0);
  assign unused_addr = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

`ifdef SLOW_MEM_RANDLAT_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;

  slow_mem_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (accept),
    .lfsr_o (lfsr)
  );

  assign cnt_load    = CNT_LOAD + {7'd0, lfsr[1:0]};
  assign unused_lfsr = ^lfsr[7:2];
`else
  assign cnt_load = CNT_LOAD;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 9'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q   <= mem_addr[DEPTH_LOG2-1:0];
            wdata_q <= mem_wdata;
            wr_q    <= mem_write;
            cnt_q   <= cnt_load;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (access) begin
            rdata_q <= mem_q[idx_q];
            ready_q <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 9'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset; access is gated by the async-reset state so a
  // write in flight when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (access && wr_q) mem_q[idx_q] <= wdata_q;
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;

endmodule
